regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file with NREAD combinational read ports, one write-back port and a per-register busy scoreboard.
- Sits between decode/issue and write-back.
- Issue marks a destination busy; write-back stores the data and clears the busy bit. Read ports return data plus a ready flag, so issue can stall on RAW hazards.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NREAD, 2, number of independent read ports, 1..4.
- AW, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- rs_data  out  NREAD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rs_ready  out  NREAD  port i data is valid (no pending producer).
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back destination.
- wb_data  in  XLEN  write-back value.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  AW  destination of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- busy_vec  out  NREGS  registered scoreboard; bit r = register r pending.

Behaviour:
- Reset (rst_n low, asynchronous): all registers <= 0, all busy bits <= 0.
  - During and after reset: busy_vec = 0, rs_ready = all 1, rs_data = 0.
- Reads are combinational and have zero latency.
  - rs_data[i] = mem[rs_addr[i]].
  - rs_ready[i] = !busy[rs_addr[i]].
  - Bypass behaviour is given under Optional Feature.
- Address 0:
  - Reads return 0 with ready = 1.
  - Writes and issues to 0 are ignored; busy[0] is constant 0.
- Write (rising edge): if wb_en && wb_addr != 0, then mem[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - A write to a non-busy register is legal: data updates, busy stays 0.
- Issue (rising edge): if iss_en && iss_addr != 0 && !flush, then busy[iss_addr] <= 1.
- Issue and write-back to the same address in the same cycle: data is written, busy ends 1 (the new producer wins).
- Issue and write-back to different addresses in the same cycle: both take effect independently.
- flush: all busy bits <= 0 at the edge.
  - A write-back in the same cycle still writes its data.
  - An issue in the same cycle is dropped.
- Multiple read ports on the same address return identical data and ready.
- No other state exists.
  - Registers reset to 0, so the block is built from flops, not RAM primitives.
- Addresses at or above NREGS cannot occur (AW is exact).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when wb_en && wb_addr == rs_addr[i] && rs_addr[i] != 0, then:
  - rs_data[i] = wb_data (same-cycle forwarding);
  - rs_ready[i] = 1, regardless of busy.
  - Adds a combinational path from wb_* to rs_*.
- Not defined: reads see the pre-edge contents. A busy register being written this cycle reports ready = 0 until the next cycle.

Test Plan:
- Reset: hold rst_n low for 3 cycles mid-operation after writing x5 = 0x1234 -> asynchronously busy_vec = 0, a read of x5 returns 0 with ready = 1.
- Write/read: wb x7 = 0xDEADBEEF, next cycle read x7 on all NREAD ports -> every port returns 0xDEADBEEF with ready = 1. wb x0 = 0xFFFFFFFF -> a read of x0 returns 0.
- Scoreboard: issue x3, next cycle busy_vec[3] = 1 and a read of x3 has ready = 0. wb x3 = 0x55 -> after the edge busy_vec[3] = 0 and the read returns 0x55 ready.
- Same-cycle issue and wb on x9 (x9 already busy, wb_data = 0xA5) -> afterwards busy_vec[9] = 1 and mem x9 = 0xA5. Issue x0 -> busy_vec[0] stays 0.
- Flush: issue x1, x2, x4 on successive cycles, then flush together with issue x6 and wb x2 = 0x77 -> busy_vec = 0, read of x2 = 0x77.
- Bypass: x12 busy, in the same cycle as wb x12 = 0xCAFE, read x12:
  - with REGFILE_BYPASS_EN: data 0xCAFE, ready = 1;
  - without it: old data, ready = 0; 0xCAFE with ready = 1 on the next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NREAD combinational read ports,
// one write-back port and a per-register busy scoreboard for RAW stalls.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rs_addr/rs_data     packed read addresses / read data (port i at slice i)
//   rs_ready            per-port "no pending producer" flag
//   wb_en/addr/data     write-back port; stores data and clears busy
//   iss_en/iss_addr     issue port; marks the destination busy
//   flush               clears every busy bit at the edge
//   busy_vec            registered scoreboard, bit r = register r pending
//
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data and readiness onto matching read ports.
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_ready,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW-1:0]    ra;

    // Write-back is applied first so that a same-address issue in the
    // same cycle re-marks the register busy (the new producer wins).
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wb_en && wb_addr != '0) begin
            mem_d[wb_addr]  = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (iss_en && iss_addr != '0) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_data  = '0;
        rs_ready = '1;
        ra       = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = rs_addr[i*AW +: AW];
            if (ra != '0) begin
                rs_data[i*XLEN +: XLEN] = mem_q[ra];
                rs_ready[i]             = ~busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wb_en && wb_addr == ra) begin
                    rs_data[i*XLEN +: XLEN] = wb_data;
                    rs_ready[i]             = 1'b1;
                end
`endif
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table, hand sequences and randomized traffic
// for regfile_sb, checked against a behavioural model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NREAD*AW-1:0]   rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_ready;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic                  flush;
    logic [NREGS-1:0]      busy_vec;

    int tests;
    int fails;

    logic [XLEN-1:0] mem_m  [NREGS];
    bit              busy_m [NREGS];

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_addr(rs_addr), .rs_data(rs_data), .rs_ready(rs_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        bit          iss_en;
        logic [4:0]  iss_addr;
        bit          flush;
        logic [4:0]  rd_addr;
        logic [31:0] exp_data;
        bit          exp_ready;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            mem_m[r]  = '0;
            busy_m[r] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge, from the block's rules.
    task automatic model_edge();
        if (!rst_n) return;
        if (wb_en && wb_addr != 0) begin
            mem_m[wb_addr]  = wb_data;
            busy_m[wb_addr] = 1'b0;
        end
        if (flush) begin
            for (int r = 0; r < NREGS; r++) busy_m[r] = 1'b0;
        end else if (iss_en && iss_addr != 0) begin
            busy_m[iss_addr] = 1'b1;
        end
    endtask

    task automatic idle();
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a);
        for (int i = 0; i < NREAD; i++) rs_addr[i*AW +: AW] = a;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Compare every read port and busy_vec with the model.
    task automatic check_model(input string tag);
        logic [4:0]  a;
        logic [31:0] ed;
        bit          er;
        logic [31:0] eb;
        eb = '0;
        for (int r = 0; r < NREGS; r++) eb[r] = busy_m[r];
        chk({tag, "_busy"}, busy_vec, eb);
        for (int i = 0; i < NREAD; i++) begin
            a  = rs_addr[i*AW +: AW];
            ed = (a == 0) ? 32'h0 : mem_m[a];
            er = (a == 0) ? 1'b1 : !busy_m[a];
`ifdef REGFILE_BYPASS_EN
            if (a != 0 && wb_en && wb_addr == a) begin
                ed = wb_data;
                er = 1'b1;
            end
`endif
            chk({tag, "_data"}, rs_data[i*XLEN +: XLEN], ed);
            chk({tag, "_rdy"}, {31'b0, rs_ready[i]}, {31'b0, er});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle();
        set_rd(5'd5);
        model_reset();

        vt[0]  = '{1, 5'd7, 32'hDEADBEEF, 0, 5'd0, 0, 5'd7, 32'hDEADBEEF, 1, 32'h0};
        vt[1]  = '{1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 0, 5'd0, 32'h0, 1, 32'h0};
        vt[2]  = '{0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, 32'h0, 0, 32'h8};
        vt[3]  = '{1, 5'd3, 32'h55, 0, 5'd0, 0, 5'd3, 32'h55, 1, 32'h0};
        vt[4]  = '{0, 5'd0, 32'h0, 1, 5'd9, 0, 5'd9, 32'h0, 0, 32'h200};
        vt[5]  = '{1, 5'd9, 32'hA5, 1, 5'd9, 0, 5'd9, 32'hA5, 0, 32'h200};
        vt[6]  = '{0, 5'd0, 32'h0, 1, 5'd0, 0, 5'd0, 32'h0, 1, 32'h200};
        vt[7]  = '{0, 5'd0, 32'h0, 1, 5'd1, 0, 5'd1, 32'h0, 0, 32'h202};
        vt[8]  = '{0, 5'd0, 32'h0, 1, 5'd2, 0, 5'd2, 32'h0, 0, 32'h206};
        vt[9]  = '{0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd4, 32'h0, 0, 32'h216};
        vt[10] = '{1, 5'd2, 32'h77, 1, 5'd6, 1, 5'd2, 32'h77, 1, 32'h0};
        vt[11] = '{0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd6, 32'h0, 1, 32'h0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_data", rs_data[31:0], 32'h0);
        chk("rst_rdy", {30'b0, rs_ready}, 32'h3);
        rst_n = 1'b1;

        // Directed table.
        for (int v = 0; v < 12; v++) begin
            wb_en    = vt[v].wb_en;
            wb_addr  = vt[v].wb_addr;
            wb_data  = vt[v].wb_data;
            iss_en   = vt[v].iss_en;
            iss_addr = vt[v].iss_addr;
            flush    = vt[v].flush;
            set_rd(5'd0);
            cycle();
            idle();
            set_rd(vt[v].rd_addr);
            #1;
            chk($sformatf("vec%0d_busy", v), busy_vec, vt[v].exp_busy);
            for (int i = 0; i < NREAD; i++) begin
                chk($sformatf("vec%0d_p%0d_data", v, i),
                    rs_data[i*XLEN +: XLEN], vt[v].exp_data);
                chk($sformatf("vec%0d_p%0d_rdy", v, i),
                    {31'b0, rs_ready[i]}, {31'b0, vt[v].exp_ready});
            end
        end

        // Asynchronous reset mid-operation.
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h1234;
        iss_en  = 1'b1;
        iss_addr = 5'd8;
        cycle();
        idle();
        set_rd(5'd5);
        #1;
        chk("pre_rst_x5", rs_data[31:0], 32'h1234);
        chk("pre_rst_busy", busy_vec, 32'h100);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_busy", busy_vec, 32'h0);
        chk("arst_x5_data", rs_data[31:0], 32'h0);
        chk("arst_x5_rdy", {31'b0, rs_ready[0]}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_busy", busy_vec, 32'h0);
        rst_n = 1'b1;

        // Same-cycle bypass on a busy register.
        iss_en   = 1'b1;
        iss_addr = 5'd12;
        cycle();
        idle();
        wb_en   = 1'b1;
        wb_addr = 5'd12;
        wb_data = 32'hCAFE;
        set_rd(5'd12);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rs_data[31:0], 32'hCAFE);
        chk("byp_rdy", {31'b0, rs_ready[0]}, 32'h1);
`else
        chk("byp_data", rs_data[31:0], 32'h0);
        chk("byp_rdy", {31'b0, rs_ready[0]}, 32'h0);
`endif
        cycle();
        idle();
        #1;
        chk("byp_next_data", rs_data[31:0], 32'hCAFE);
        chk("byp_next_rdy", {31'b0, rs_ready[0]}, 32'h1);
        chk("byp_next_busy", busy_vec, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_addr  = 5'($urandom_range(0, 31));
            wb_data  = $urandom;
            iss_en   = ($urandom_range(0, 2) != 0);
            iss_addr = 5'($urandom_range(0, 31));
            flush    = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NREAD; i++) begin
                rs_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ?
                    wb_addr : 5'($urandom_range(0, 31));
            end
            #1;
            check_model($sformatf("rnd%0d", n));
            cycle();
        end
        idle();
        #1;
        check_model("rnd_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
